// File: rtl/ring_fifo_pkg.sv
// Shared definitions for the ring buffers in the memories directory:
// depth/count-width helpers, default parameters and the flag bundle.
package ring_fifo_pkg;

  localparam int unsigned DEF_BITS  = 32'd8;
  localparam int unsigned DEF_WIDHT = 32'd2;
  localparam int unsigned DEF_AFULL = 32'd3;

  function automatic int unsigned depth_f(input int unsigned widht);
    return 32'd1 << widht;
  endfunction

  // One extra bit so the count can represent a completely full buffer
  function automatic int unsigned cnt_width_f(input int unsigned widht);
    return widht + 32'd1;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic afull;
    logic overflow;
    logic underflow;
  } ring_flags_t;

endpackage

// File: rtl/ring_fifo_if.sv
// Push/pop handshake and status bundle of ring_fifo; master is the
// client that pushes and pops, slave is the buffer itself.
interface ring_fifo_if #(
  parameter int unsigned pBITS  = 32'd8,
  parameter int unsigned pWIDHT = 32'd2
);

  logic              iwr_en;
  logic [pBITS-1:0]  iw_data;
  logic              ird_en;
  logic [pBITS-1:0]  or_data;
  logic              oempty;
  logic              ofull;
  logic              oafull;
  logic [pWIDHT:0]   ocount;
  logic              ooverflow;
  logic              ounderflow;

  modport master (
    output iwr_en, iw_data, ird_en,
    input  or_data, oempty, ofull, oafull, ocount, ooverflow, ounderflow
  );

  modport slave (
    input  iwr_en, iw_data, ird_en,
    output or_data, oempty, ofull, oafull, ocount, ooverflow, ounderflow
  );

endinterface

// File: rtl/ring_fifo_ptr.sv
// Wrapping pWIDHT-bit pointer with synchronous active-high reset and an
// increment enable; wrap-around is plain binary rollover.
module ring_ptr #(
  parameter int unsigned pWIDHT = 32'd2
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              iinc,
  output logic [pWIDHT-1:0] optr
);

  // Pointer register: reset to slot 0, advance one slot per accepted access
  always_ff @(posedge iclk) begin
    if (irst) begin
      optr <= '0;
    end else if (iinc) begin
      optr <= optr + pWIDHT'(1'b1);
    end else begin
      optr <= optr;
    end
  end

endmodule

// File: rtl/ring_fifo.sv
// First-word-fall-through ring buffer over a sync-write / async-read
// register array with occupancy count, level flags and error pulses.
module ring_fifo
  import ring_fifo_pkg::*;
#(
  parameter int unsigned pBITS  = DEF_BITS,
  parameter int unsigned pWIDHT = DEF_WIDHT,
  parameter int unsigned pAFULL = DEF_AFULL
) (
  input  logic     iclk,
  input  logic     irst,
  ring_fifo_if.slave bus
);

  localparam int unsigned DEPTH = depth_f(pWIDHT);
  localparam int unsigned CW    = cnt_width_f(pWIDHT);

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(pAFULL);
  localparam logic [CW-1:0] ZERO_CNT  = {CW{1'b0}};

  // An illegal zero threshold keeps almost-full asserted even out of reset
  localparam ring_flags_t RST_FLAGS = '{
    empty:     1'b1,
    full:      1'b0,
    afull:     (pAFULL == 32'd0),
    overflow:  1'b0,
    underflow: 1'b0
  };

  logic [pBITS-1:0]  mem_r [DEPTH];
  logic [pWIDHT-1:0] wr_ptr_s;
  logic [pWIDHT-1:0] rd_ptr_s;
  logic              wr_ok_s;
  logic              rd_ok_s;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_nxt_s;
  ring_flags_t       flags_r;
  ring_flags_t       flags_nxt_s;

  ring_ptr #(.pWIDHT(pWIDHT)) u_wr_ptr (
    .iclk (iclk),
    .irst (irst),
    .iinc (wr_ok_s),
    .optr (wr_ptr_s)
  );

  ring_ptr #(.pWIDHT(pWIDHT)) u_rd_ptr (
    .iclk (iclk),
    .irst (irst),
    .iinc (rd_ok_s),
    .optr (rd_ptr_s)
  );

  // Accept decisions and next count/flags; a pop frees the slot a full push needs
  always_comb begin
    wr_ok_s     = bus.iwr_en & (~flags_r.full | bus.ird_en);
    rd_ok_s     = bus.ird_en & ~flags_r.empty;
    count_nxt_s = count_r + CW'(wr_ok_s) - CW'(rd_ok_s);

    flags_nxt_s           = RST_FLAGS;
    flags_nxt_s.empty     = (count_nxt_s == ZERO_CNT);
    flags_nxt_s.full      = (count_nxt_s == FULL_CNT);
    flags_nxt_s.afull     = (count_nxt_s >= AFULL_CNT);
    flags_nxt_s.overflow  = bus.iwr_en & ~wr_ok_s;
    flags_nxt_s.underflow = bus.ird_en & flags_r.empty;
  end

  // Count and flag registers; flags track the count on the same edge
  always_ff @(posedge iclk) begin
    if (irst) begin
      count_r <= ZERO_CNT;
      flags_r <= RST_FLAGS;
    end else begin
      count_r <= count_nxt_s;
      flags_r <= flags_nxt_s;
    end
  end

  // Storage is never cleared; reset only suppresses a same-cycle write
  always_ff @(posedge iclk) begin
    if (!irst && wr_ok_s) begin
      mem_r[wr_ptr_s] <= bus.iw_data;
    end
  end

  assign bus.or_data    = mem_r[rd_ptr_s];
  assign bus.ocount     = count_r;
  assign bus.oempty     = flags_r.empty;
  assign bus.ofull      = flags_r.full;
  assign bus.oafull     = flags_r.afull;
  assign bus.ooverflow  = flags_r.overflow;
  assign bus.ounderflow = flags_r.underflow;

endmodule

// File: tb/tb_ring_fifo.sv
// Directed-vector bench for ring_fifo (pBITS=8, pWIDHT=2, pAFULL=3).
module tb_ring_fifo;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  ring_fifo_if #(.pBITS(8), .pWIDHT(2)) bus ();

  ring_fifo #(.pBITS(8), .pWIDHT(2), .pAFULL(3)) dut (
    .iclk (clk),
    .irst (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic emp, input logic ful,
                           input logic afl, input logic ovf, input logic unf);
    chk_vec({tag, ".count"}, 16'(bus.ocount), 16'(cnt));
    chk_vec({tag, ".empty"}, 16'(bus.oempty), 16'(emp));
    chk_vec({tag, ".full"}, 16'(bus.ofull), 16'(ful));
    chk_vec({tag, ".afull"}, 16'(bus.oafull), 16'(afl));
    chk_vec({tag, ".ovf"}, 16'(bus.ooverflow), 16'(ovf));
    chk_vec({tag, ".unf"}, 16'(bus.ounderflow), 16'(unf));
  endtask

  initial begin
    logic [7:0] fill  [4];
    logic [7:0] drain [4];
    fill  = '{8'h11, 8'h22, 8'h33, 8'h44};
    drain = '{8'h62, 8'h63, 8'h64, 8'h66};
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.iwr_en = 1'b0;
    bus.ird_en = 1'b0;
    bus.iw_data = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk_state("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("idle", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill to full; head stays on the first word
    for (int i = 0; i < 4; i++) begin
      bus.iwr_en = 1'b1;
      bus.iw_data = fill[i];
      tick();
      chk_state("fill", i + 1, 1'b0, (i == 3), (i >= 2), 1'b0, 1'b0);
      chk_vec("fill.head", 16'(bus.or_data), 16'h11);
    end

    // Push into a full buffer is rejected
    bus.iw_data = 8'h55;
    tick();
    chk_state("ovf", 4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_vec("ovf.head", 16'(bus.or_data), 16'h11);
    bus.iwr_en = 1'b0;
    bus.ird_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_vec("pop.data", 16'(bus.or_data), 16'(fill[i]));
      tick();
      chk_vec("pop.count", 16'(bus.ocount), 16'(3 - i));
      chk_vec("pop.ovf", 16'(bus.ooverflow), 16'h0);
    end
    bus.ird_en = 1'b0;
    chk_state("drained", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Streaming with overlap across several pointer wraps
    bus.iwr_en = 1'b1;
    bus.iw_data = 8'hA0;
    tick();
    bus.iw_data = 8'hA1;
    tick();
    chk_vec("wrap.prime", 16'(bus.ocount), 16'd2);
    bus.ird_en = 1'b1;
    for (int i = 2; i < 10; i++) begin
      bus.iw_data = 8'hA0 + 8'(i);
      chk_vec("wrap.data", 16'(bus.or_data), 16'(8'hA0 + 8'(i - 2)));
      tick();
      chk_vec("wrap.count", 16'(bus.ocount), 16'd2);
    end
    bus.iwr_en = 1'b0;
    for (int i = 8; i < 10; i++) begin
      chk_vec("wrap.tail", 16'(bus.or_data), 16'(8'hA0 + 8'(i)));
      tick();
    end
    bus.ird_en = 1'b0;
    chk_state("wrap.end", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full plus simultaneous push/pop
    bus.iwr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.iw_data = 8'h61 + 8'(i);
      tick();
    end
    chk_vec("full2.full", 16'(bus.ofull), 16'h1);
    chk_vec("full2.head", 16'(bus.or_data), 16'h61);
    bus.iw_data = 8'h66;
    bus.ird_en = 1'b1;
    tick();
    chk_state("full2.both", 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.iwr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_vec("full2.drain", 16'(bus.or_data), 16'(drain[i]));
      tick();
    end
    chk_state("full2.end", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pop from empty, then empty plus simultaneous push/pop
    tick();
    chk_state("unf", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.iwr_en = 1'b1;
    bus.iw_data = 8'h77;
    tick();
    chk_state("empty.both", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_vec("empty.both.data", 16'(bus.or_data), 16'h77);
    bus.iwr_en = 1'b0;
    bus.ird_en = 1'b0;
    tick();
    chk_state("unf.clear", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.ird_en = 1'b1;
    tick();
    bus.ird_en = 1'b0;
    chk_state("unf.pop", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream discards the concurrent push
    bus.iwr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.iw_data = 8'h81 + 8'(i);
      tick();
    end
    chk_state("pre.rst", 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.iw_data = 8'h99;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.iwr_en = 1'b0;
    chk_state("mid.rst", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("post.rst", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.iwr_en = 1'b1;
    bus.iw_data = 8'h88;
    tick();
    bus.iwr_en = 1'b0;
    chk_state("rst.push", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_vec("rst.push.data", 16'(bus.or_data), 16'h88);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ring_fifo.md
Name: ring_fifo

Overview:
- Parametrised circular (ring) buffer built on a synchronous-write, asynchronous-read register array.
- Sits between the packet-copy stages in the memories directory.
- Adds over a plain register file: self-managed read/write pointers with wrap-around, occupancy count, full/empty/almost-full flags, overflow/underflow error pulses and synchronous reset of all control state.
- Data is first-word-fall-through: the head entry is always presented on the output.

Parameters:
- pBITS, 8, data word width in bits.
- pWIDHT, 2, pointer/address width; depth = 2**pWIDHT entries.
- pAFULL, 3, almost-full threshold; oafull asserts when count >= pAFULL (legal range 1..2**pWIDHT).

Ports:
- iclk  input  1  single clock; all state updates on its rising edge.
- irst  input  1  reset, synchronous, active-high.
- iwr_en  input  1  push request.
- iw_data  input  pBITS  push data.
- ird_en  input  1  pop request (acknowledges the word on or_data).
- or_data  output  pBITS  head word, FWFT; don't-care while oempty=1.
- oempty  output  1  count == 0.
- ofull  output  1  count == 2**pWIDHT.
- oafull  output  1  count >= pAFULL.
- ocount  output  pWIDHT+1  current occupancy, 0..2**pWIDHT.
- ooverflow  output  1  one-cycle pulse: push rejected because the buffer was full.
- ounderflow  output  1  one-cycle pulse: pop rejected because the buffer was empty.

Behaviour:
- Reset (irst=1 at a clock edge):
  - wr_ptr=0, rd_ptr=0, ocount=0, oempty=1, ofull=0, oafull=0 (or 1 if pAFULL=0, which is illegal), ooverflow=0, ounderflow=0.
  - Storage contents are not cleared.
  - Reset dominates any iwr_en/ird_en in the same cycle, and aborts any operation in progress.
- Accept conditions, evaluated against registered state before the edge:
  - wr_ok = iwr_en & (~ofull | ird_en).
  - rd_ok = ird_en & ~oempty.
- Write: when wr_ok, array[wr_ptr] <= iw_data and wr_ptr <= wr_ptr+1, wrapping 2**pWIDHT-1 -> 0 (natural pWIDHT-bit rollover).
- Read: when rd_ok, rd_ptr <= rd_ptr+1 with the same wrap.
- or_data = array[rd_ptr], combinational. Latency from push to visible on or_data when empty is 1 cycle (the next cycle after the write edge).
- Count update: ocount <= ocount + wr_ok - rd_ok, computed at pWIDHT+1 bits. It never exceeds 2**pWIDHT or goes below 0.
- Flags are registered outputs derived from the next count, so flags and ocount change on the same edge.
- Simultaneous push and pop:
  - Non-empty, non-full: both occur; count unchanged.
  - Full: both occur (pop frees the slot); no overflow; count stays full.
  - Empty: the pop is rejected (ounderflow pulses) and the push occurs; count becomes 1.
- Error pulses:
  - ooverflow <= iwr_en & ~wr_ok.
  - ounderflow <= ird_en & oempty.
  - Both are registered, high for exactly one cycle after the offending edge, and cleared by reset.
- Rejected operations leave pointers, count and storage untouched.
- No state machine beyond the pointer/count registers. Wrap-around is the only address transition.

Decomposition:
- Shared package/include (memories_pkg): depth localparam = 2**pWIDHT and a count-width localparam, reused by the other buffers in the directory.
- One natural sub-module, ring_ptr: a pWIDHT-bit wrapping pointer with synchronous active-high reset and increment enable. It is instantiated twice (write and read).
- Storage array and flag logic stay in ring_fifo.

Test Plan (pBITS=8, pWIDHT=2, pAFULL=3):
- Reset, then idle -> oempty=1, ofull=0, oafull=0, ocount=0, no error pulses.
- Push 0x11,0x22,0x33,0x44 on consecutive cycles -> ocount 1,2,3,4; oafull rises with ocount=3; ofull=1 at 4; or_data=0x11 from the cycle after the first push.
- Full, push 0x55 with ird_en=0 -> ooverflow pulses 1 cycle, ocount stays 4. Then pop x4 -> or_data 0x11,0x22,0x33,0x44, then oempty=1 (0x55 never appears).
- Pointer wrap: push/pop 10 words 0xA0..0xA9 keeping ocount=2 with simultaneous push+pop -> output order exactly 0xA0..0xA9, ocount constant at 2 during overlap.
- Full plus simultaneous push 0x66/pop -> or_data advances, ocount=4, ooverflow=0. Empty plus simultaneous push 0x77/pop -> ounderflow pulses, ocount=1, or_data=0x77.
- irst asserted mid-stream with ocount=3 and iwr_en=1 -> next cycle ocount=0, oempty=1, flags cleared, pushed word discarded. Then push 0x88 -> or_data=0x88.
